// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the 1-to-4 stream demultiplexer slice.
//   N_CH       : number of output channels
//   ch_sel_t   : channel select code (0..3)
//   stat_cnt_t : width of the optional input-transfer counter
//   sel_onehot : decodes a channel select into a one-hot channel mask
package demux_pkg;

  localparam int unsigned N_CH = 4;

  typedef logic [1:0] ch_sel_t;
  typedef logic [7:0] stat_cnt_t;

  function automatic logic [N_CH-1:0] sel_onehot(input ch_sel_t sel);
    logic [N_CH-1:0] mask;
    mask = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_1_4_width_2.sv
// demux_1_4_width_2
//   Purely combinational 2-bit, 1-to-4 demultiplexer slice.
//   d      in  [1:0] : data bits to route
//   sel    in  [1:0] : destination output
//   y0..y3 out [1:0] : selected output carries d, all others are zero
module demux_1_4_width_2
  import demux_pkg::*;
(
  input  logic [1:0] d,
  input  logic [1:0] sel,
  output logic [1:0] y0,
  output logic [1:0] y1,
  output logic [1:0] y2,
  output logic [1:0] y3
);

  always_comb begin
    y0 = '0;
    y1 = '0;
    y2 = '0;
    y3 = '0;
    case (ch_sel_t'(sel))
      2'd0:    y0 = d;
      2'd1:    y1 = d;
      2'd2:    y2 = d;
      default: y3 = d;
    endcase
  end

endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream
//   Valid/ready stream demultiplexer: one input stream routed by in_sel to
//   one of four output channels, each with a one-entry holding register.
//   A channel may drain and refill in the same cycle without a bubble.
//
//   Parameters
//     WIDTH      : data width per word (even, >= 2)
//   Ports
//     clk        in            : clock, rising edge
//     rst_n      in            : asynchronous active-low reset
//     in_valid   in            : input word present
//     in_ready   out           : input word accepted this cycle
//     in_data    in  [WIDTH]   : input word
//     in_sel     in  [2]       : destination channel
//     out_valid  out [4]       : per-channel word held
//     out_ready  in  [4]       : per-channel consumer takes the word
//     out_d0..3  out [WIDTH]   : per-channel held word
//     stat_cnt   out [8]       : input-transfer count, wraps 255->0
//                                (present only with DEMUX_1_4_STREAM_STATS_EN)
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_d0,
  output logic [WIDTH-1:0] out_d1,
  output logic [WIDTH-1:0] out_d2,
  output logic [WIDTH-1:0] out_d3
`ifdef DEMUX_1_4_STREAM_STATS_EN
  ,
  output logic [7:0]       stat_cnt
`endif
);

  localparam int unsigned N_SLICE = WIDTH / 2;

  logic [N_CH-1:0]             valid_q;
  logic [N_CH-1:0]             valid_d;
  logic [WIDTH-1:0]            data_q [N_CH];
  logic [N_CH-1:0][WIDTH-1:0]  ld_word;
  logic [N_CH-1:0]             load_vec;
  logic [N_CH-1:0]             drain_vec;
  logic                        in_fire;

  // in_ready looks through to out_ready so a full channel being drained
  // this cycle can accept its next word on the same edge.
  assign in_ready  = !valid_q[in_sel] || out_ready[in_sel];
  assign in_fire   = in_valid && in_ready;
  assign load_vec  = in_fire ? sel_onehot(ch_sel_t'(in_sel)) : '0;
  assign drain_vec = valid_q & out_ready;

  // Load datapath built from 2-bit demux slices; each slice routes its
  // bit pair to the selected channel's load word and zeros the others.
  for (genvar g = 0; g < N_SLICE; g++) begin : g_slice
    demux_1_4_width_2 u_slice (
      .d   (in_data[2*g+1:2*g]),
      .sel (in_sel),
      .y0  (ld_word[0][2*g+1:2*g]),
      .y1  (ld_word[1][2*g+1:2*g]),
      .y2  (ld_word[2][2*g+1:2*g]),
      .y3  (ld_word[3][2*g+1:2*g])
    );
  end

  // A load wins over a drain, giving bubble-free drain+refill.
  always_comb begin
    valid_d = (valid_q & ~drain_vec) | load_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (load_vec[i]) begin
          data_q[i] <= ld_word[i];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_d0    = data_q[0];
  assign out_d1    = data_q[1];
  assign out_d2    = data_q[2];
  assign out_d3    = data_q[3];

`ifdef DEMUX_1_4_STREAM_STATS_EN
  stat_cnt_t cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_fire) begin
      cnt_q <= cnt_q + stat_cnt_t'(1);
    end
  end

  assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = '0;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
`ifdef DEMUX_1_4_STREAM_STATS_EN
  logic [7:0]   stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel occupancy and word, plus transfer count.
  bit           mv [4];
  int unsigned  md [4];
  int unsigned  mcnt;

  demux_1_4_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3)
`ifdef DEMUX_1_4_STREAM_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    mcnt = 0;
  endtask

  function automatic bit model_ready();
    return !mv[in_sel] || out_ready[in_sel];
  endfunction

  task automatic check_outputs();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mv[i];
    chk("out_valid", out_valid, v);
    chk("out_d0", out_d0, md[0]);
    chk("out_d1", out_d1, md[1]);
    chk("out_d2", out_d2, md[2]);
    chk("out_d3", out_d3, md[3]);
`ifdef DEMUX_1_4_STREAM_STATS_EN
    chk("stat_cnt", stat_cnt, mcnt);
`endif
  endtask

  // Called at posedge+1: apply inputs, then check combinational in_ready.
  task automatic drive(input bit iv, input int sel, input int data, input logic [3:0] ordy);
    in_valid  = iv;
    in_sel    = 2'(sel);
    in_data   = W'(data);
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, model_ready());
  endtask

  // Advance one edge, update the model from the applied inputs, check.
  task automatic tick();
    bit fire;
    int s;
    @(posedge clk);
    fire = in_valid && model_ready();
    s = in_sel;
    for (int i = 0; i < 4; i++)
      if (mv[i] && out_ready[i]) mv[i] = 0;
    if (fire) begin
      mv[s] = 1;
      md[s] = in_data;
      mcnt  = (mcnt + 1) % 256;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Routing: one word per channel, all consumers ready.
    drive(1, 0, 'ha, 4'b1111); tick(); chk("route_v0", out_valid, 4'b0001); chk("route_d0", out_d0, 'ha);
    drive(1, 1, 'hb, 4'b1111); tick(); chk("route_v1", out_valid, 4'b0010); chk("route_d1", out_d1, 'hb);
    drive(1, 2, 'hc, 4'b1111); tick(); chk("route_v2", out_valid, 4'b0100); chk("route_d2", out_d2, 'hc);
    drive(1, 3, 'hd, 4'b1111); tick(); chk("route_v3", out_valid, 4'b1000); chk("route_d3", out_d3, 'hd);
    drive(0, 0, 0, 4'b1111); tick(); chk("route_empty", out_valid, 4'b0000);

    // Backpressure on channel 2, then drain+refill on the same edge.
    drive(1, 2, 'h5, 4'b1011); tick();
    drive(1, 2, 'h6, 4'b1011); chk("bp_in_ready", in_ready, 1'b0);
    tick(); chk("bp_hold_d2", out_d2, 'h5); chk("bp_hold_v2", out_valid[2], 1'b1);
    drive(1, 2, 'h6, 4'b1111); chk("bp_rdy_up", in_ready, 1'b1);
    tick(); chk("bp_refill_v2", out_valid[2], 1'b1); chk("bp_refill_d2", out_d2, 'h6);
    drive(0, 0, 0, 4'b1111); tick();

    // Independence: channel 0 stalled and full, channel 1 still accepts.
    drive(1, 0, 'h3, 4'b1110); tick();
    drive(1, 1, 'h9, 4'b1110); chk("ind_in_ready", in_ready, 1'b1);
    tick(); chk("ind_d1", out_d1, 'h9); chk("ind_d0", out_d0, 'h3); chk("ind_v0", out_valid[0], 1'b1);
    drive(0, 0, 0, 4'b1111); tick();

    // Simultaneous partial drain.
    for (int i = 0; i < 4; i++) begin
      drive(1, i, i + 1, 4'b0000); tick();
    end
    chk("sim_full", out_valid, 4'b1111);
    drive(0, 0, 0, 4'b0101); tick();
    chk("sim_valid", out_valid, 4'b1010); chk("sim_d1", out_d1, 'h2); chk("sim_d3", out_d3, 'h4);

    // Asynchronous reset mid-stream with channels 1 and 3 full.
    drive(0, 0, 0, 4'b0000);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", out_valid, 4'b0000);
    chk("arst_d0", out_d0, 0); chk("arst_d1", out_d1, 0);
    chk("arst_d2", out_d2, 0); chk("arst_d3", out_d3, 0);
    chk("arst_in_ready", in_ready, 1'b1);
`ifdef DEMUX_1_4_STREAM_STATS_EN
    chk("arst_stat", stat_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15), 4'($urandom));
      tick();
    end

    // Counter wrap: 257 transfers from reset.
    drive(0, 0, 0, 4'b1111);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 257; n++) begin
      drive(1, n % 4, n % 16, 4'b1111); tick();
    end
`ifdef DEMUX_1_4_STREAM_STATS_EN
    chk("stat_257", stat_cnt, 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
